voice_table: RTL and testbench
==============================

// Module: voice_table
// PURPOSE
//  Per-voice state store directly downstream of the SPI MIDI decoder.
//  Captures note-on/note-off events (voice index, tuning code, velocity) into a register file.
//  Replays all voices as a round-robin scan stream to the time-multiplexed DDS/ADSR pipeline.
//  The stream carries gate level plus one-shot trigger/release markers.
// PARAMETERS
//  NUM_VOICES  16  number of voice slots; must equal 2**VOICE_W
//  VOICE_W     4   width of scan voice index
//  TUNE_W      32  tuning code width (DDS phase increment)
//  VEL_W       7   MIDI velocity width
// PORTS
//  i_clk          in   1       system clock
//  i_reset        in   1       synchronous, active-high reset
//  i_note_status  in   1       1=note-on, 0=note-off; valid with strobes
//  i_voice_index  in   8       target voice; values >= NUM_VOICES are dropped
//  i_tuning_code  in   TUNE_W  tuning code; valid with i_flag_dds
//  i_velocity     in   VEL_W   velocity; valid with i_flag_adsr
//  i_flag_dds     in   1       1-cycle strobe: tuning code update
//  i_flag_adsr    in   1       1-cycle strobe: note event (on or off)
//  i_scan_en      in   1       advance scan by one voice this cycle
//  o_valid        out  1       scan output valid this cycle
//  o_voice        out  VOICE_W voice index of scan output
//  o_frame_start  out  1       high with o_valid when o_voice==0
//  o_tuning_code  out  TUNE_W  stored tuning code of o_voice
//  o_velocity     out  VEL_W   stored velocity of o_voice
//  o_gate         out  1       1 while note held
//  o_trigger      out  1       one-shot: first scan of voice after note-on
//  o_release      out  1       one-shot: first scan of voice after note-off
//  o_drop_count   out  8       saturating count of out-of-range events
// BEHAVIOUR
//  Reset: scan ptr=0; all tuning/velocity/gate/trig_pend/rel_pend=0.
//  Reset: all outputs 0 (o_valid=0, o_drop_count=0). Mid-operation reset clears everything in 1 cycle.
//  Event write, index in range, evaluated each cycle:
//   - i_flag_dds: tuning[v] <= i_tuning_code.
//   - i_flag_adsr & status=1: vel[v]<=i_velocity; gate[v]<=1; trig_pend[v]<=1; rel_pend[v]<=0.
//   - i_flag_adsr & status=0: gate[v]<=0; rel_pend[v]<=1; trig_pend[v]<=0; tuning and velocity retained.
//   - Note-on to an already gated voice: retrigger (trig_pend=1, values overwritten).
//   - Strobe held >1 cycle: each cycle is a separate event (idempotent).
//  Index >= NUM_VOICES: no state change; o_drop_count += 1, saturating at 255.
//  Scan:
//   - Cycle n with i_scan_en=1 reads voice p=ptr; outputs registered and valid in cycle n+1.
//   - Outputs: o_valid=1, o_voice=p, o_frame_start=(p==0).
//   - ptr <= ptr+1, wrapping NUM_VOICES-1 -> 0.
//   - i_scan_en=0: o_valid=0; o_trigger/o_release=0; other outputs hold; ptr holds.
//  Read clears pending flags: o_trigger=trig_pend[p], o_release=rel_pend[p]; both cleared for p.
//  Collision, same-cycle event to voice p while p is scanned: write-through.
//   - Output shows post-event tuning, velocity and gate.
//   - Trigger/release of that event is delivered in this output and not left pending.
//  Collision: o_trigger and o_release never both 1; the newer event wins.
//  Latency: event strobe at cycle n is visible no earlier than scan read in cycle n (write-through).
//  Latency: worst case NUM_VOICES scan steps.
// TESTING
//  1. Reset then 16 scan_en cycles -> o_voice 0..15, o_frame_start only at voice 0, all gate/trigger 0.
//  2. Note-on v=3, tune=0x0123_4567, vel=100 -> next scan of 3: gate=1, trigger=1, values match.
//     Following frame: gate=1, trigger=0.
//  3. Note-off v=3 -> next scan: gate=0, release=1, tune still 0x0123_4567; next frame release=0.
//  4. Note-on v=5 strobed in same cycle ptr=5 is read -> output cycle: gate=1, trigger=1.
//     Next frame: trigger=0.
//  5. 300 events with index=200 -> no voice changes, o_drop_count=255.
//  6. Reset asserted with pending trigger on v=7 -> after reset, full frame shows v=7 gate=0, trigger=0.

Source files
------------

// File: rtl/voice_table.sv
// voice_table: per-voice note state captured from decoded MIDI events and
// replayed as a round-robin scan stream for the shared DDS/ADSR pipeline.
module voice_table #(
  parameter int NUM_VOICES = 16,
  parameter int VOICE_W    = 4,
  parameter int TUNE_W     = 32,
  parameter int VEL_W      = 7
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_note_status,
  input  logic [7:0]         i_voice_index,
  input  logic [TUNE_W-1:0]  i_tuning_code,
  input  logic [VEL_W-1:0]   i_velocity,
  input  logic               i_flag_dds,
  input  logic               i_flag_adsr,
  input  logic               i_scan_en,
  output logic               o_valid,
  output logic [VOICE_W-1:0] o_voice,
  output logic               o_frame_start,
  output logic [TUNE_W-1:0]  o_tuning_code,
  output logic [VEL_W-1:0]   o_velocity,
  output logic               o_gate,
  output logic               o_trigger,
  output logic               o_release,
  output logic [7:0]         o_drop_count
);

  // Voice register file
  logic [TUNE_W-1:0]     tune_q [NUM_VOICES];
  logic [TUNE_W-1:0]     tune_d [NUM_VOICES];
  logic [VEL_W-1:0]      vel_q  [NUM_VOICES];
  logic [VEL_W-1:0]      vel_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic [NUM_VOICES-1:0] rel_q,  rel_d;

  // Scan pointer and registered stream outputs
  logic [VOICE_W-1:0] ptr_q,   ptr_d;
  logic               valid_q, valid_d;
  logic [VOICE_W-1:0] voice_q, voice_d;
  logic               frame_q, frame_d;
  logic [TUNE_W-1:0]  otune_q, otune_d;
  logic [VEL_W-1:0]   ovel_q,  ovel_d;
  logic               ogate_q, ogate_d;
  logic               otrig_q, otrig_d;
  logic               orel_q,  orel_d;
  logic [7:0]         drop_q,  drop_d;

  logic               in_range;
  logic [VOICE_W-1:0] evt_v;

  assign in_range = ({1'b0, i_voice_index} < 9'(NUM_VOICES));
  assign evt_v    = i_voice_index[VOICE_W-1:0];

  // Apply this cycle's event first, then read the scanned voice from the
  // updated view so a same-cycle event to that voice writes through and its
  // one-shot marker is consumed by this read instead of staying pending.
  always_comb begin
    tune_d  = tune_q;
    vel_d   = vel_q;
    gate_d  = gate_q;
    trig_d  = trig_q;
    rel_d   = rel_q;
    ptr_d   = ptr_q;
    drop_d  = drop_q;
    valid_d = 1'b0;
    voice_d = voice_q;
    frame_d = 1'b0;
    otune_d = otune_q;
    ovel_d  = ovel_q;
    ogate_d = ogate_q;
    otrig_d = 1'b0;
    orel_d  = 1'b0;

    if (i_flag_dds || i_flag_adsr) begin
      if (in_range) begin
        if (i_flag_dds) tune_d[evt_v] = i_tuning_code;
        if (i_flag_adsr) begin
          if (i_note_status) begin
            vel_d[evt_v]  = i_velocity;
            gate_d[evt_v] = 1'b1;
            trig_d[evt_v] = 1'b1;
            rel_d[evt_v]  = 1'b0;
          end else begin
            gate_d[evt_v] = 1'b0;
            trig_d[evt_v] = 1'b0;
            rel_d[evt_v]  = 1'b1;
          end
        end
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end

    if (i_scan_en) begin
      valid_d       = 1'b1;
      voice_d       = ptr_q;
      frame_d       = (ptr_q == '0);
      otune_d       = tune_d[ptr_q];
      ovel_d        = vel_d[ptr_q];
      ogate_d       = gate_d[ptr_q];
      otrig_d       = trig_d[ptr_q];
      orel_d        = rel_d[ptr_q];
      trig_d[ptr_q] = 1'b0;
      rel_d[ptr_q]  = 1'b0;
      ptr_d         = ptr_q + 1'b1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tune_q  <= '{default: '0};
      vel_q   <= '{default: '0};
      gate_q  <= '0;
      trig_q  <= '0;
      rel_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      voice_q <= '0;
      frame_q <= 1'b0;
      otune_q <= '0;
      ovel_q  <= '0;
      ogate_q <= 1'b0;
      otrig_q <= 1'b0;
      orel_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      tune_q  <= tune_d;
      vel_q   <= vel_d;
      gate_q  <= gate_d;
      trig_q  <= trig_d;
      rel_q   <= rel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      voice_q <= voice_d;
      frame_q <= frame_d;
      otune_q <= otune_d;
      ovel_q  <= ovel_d;
      ogate_q <= ogate_d;
      otrig_q <= otrig_d;
      orel_q  <= orel_d;
      drop_q  <= drop_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_voice       = voice_q;
  assign o_frame_start = frame_q;
  assign o_tuning_code = otune_q;
  assign o_velocity    = ovel_q;
  assign o_gate        = ogate_q;
  assign o_trigger     = otrig_q;
  assign o_release     = orel_q;
  assign o_drop_count  = drop_q;

endmodule

// File: tb/tb_voice_table.sv
// Testbench for voice_table: directed scenarios plus randomized traffic,
// checked against a behavioural per-voice model.
module tb_voice_table;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_note_status = 1'b0;
  logic [7:0]  i_voice_index = '0;
  logic [31:0] i_tuning_code = '0;
  logic [6:0]  i_velocity = '0;
  logic        i_flag_dds = 1'b0;
  logic        i_flag_adsr = 1'b0;
  logic        i_scan_en = 1'b0;
  logic        o_valid;
  logic [3:0]  o_voice;
  logic        o_frame_start;
  logic [31:0] o_tuning_code;
  logic [6:0]  o_velocity;
  logic        o_gate;
  logic        o_trigger;
  logic        o_release;
  logic [7:0]  o_drop_count;

  int checks = 0;
  int errors = 0;

  voice_table #(.NUM_VOICES(16), .VOICE_W(4), .TUNE_W(32), .VEL_W(7)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_note_status(i_note_status),
    .i_voice_index(i_voice_index), .i_tuning_code(i_tuning_code),
    .i_velocity(i_velocity), .i_flag_dds(i_flag_dds), .i_flag_adsr(i_flag_adsr),
    .i_scan_en(i_scan_en), .o_valid(o_valid), .o_voice(o_voice),
    .o_frame_start(o_frame_start), .o_tuning_code(o_tuning_code),
    .o_velocity(o_velocity), .o_gate(o_gate), .o_trigger(o_trigger),
    .o_release(o_release), .o_drop_count(o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural model: per-voice note records and a scan position.
  int m_tune [16];
  int m_vel  [16];
  bit m_gate [16];
  bit m_trig [16];
  bit m_rel  [16];
  int m_ptr;
  int m_drop;
  bit e_valid, e_fs, e_gate, e_trig, e_rel;
  int e_voice, e_tune, e_vel;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_tune[i] = 0; m_vel[i] = 0; m_gate[i] = 0; m_trig[i] = 0; m_rel[i] = 0;
    end
    m_ptr = 0; m_drop = 0;
    e_valid = 0; e_fs = 0; e_gate = 0; e_trig = 0; e_rel = 0;
    e_voice = 0; e_tune = 0; e_vel = 0;
  endfunction

  function automatic void model_step(input bit scan, input bit dds, input bit adsr,
                                     input bit st, input int idx, input int tune,
                                     input int vel);
    if (dds || adsr) begin
      if (idx >= 16) begin
        m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
      end else begin
        if (dds) m_tune[idx] = tune;
        if (adsr && st) begin
          m_vel[idx] = vel; m_gate[idx] = 1; m_trig[idx] = 1; m_rel[idx] = 0;
        end else if (adsr) begin
          m_gate[idx] = 0; m_rel[idx] = 1; m_trig[idx] = 0;
        end
      end
    end
    e_trig = 0; e_rel = 0; e_fs = 0; e_valid = scan;
    if (scan) begin
      e_voice = m_ptr; e_fs = (m_ptr == 0);
      e_tune = m_tune[m_ptr]; e_vel = m_vel[m_ptr]; e_gate = m_gate[m_ptr];
      e_trig = m_trig[m_ptr]; e_rel = m_rel[m_ptr];
      m_trig[m_ptr] = 0; m_rel[m_ptr] = 0;
      m_ptr = (m_ptr + 1) % 16;
    end
  endfunction

  function automatic logic [54:0] got_vec();
    return {o_valid, o_voice, o_tuning_code, o_velocity, o_gate, o_trigger, o_release, o_drop_count};
  endfunction

  function automatic logic [54:0] exp_vec();
    return {e_valid, 4'(e_voice), 32'(e_tune), 7'(e_vel), e_gate, e_trig, e_rel, 8'(m_drop)};
  endfunction

  // One clock with the given inputs; the model advances on the same edge.
  task automatic cycle(input logic scan, input logic dds, input logic adsr, input logic st,
                       input logic [7:0] idx, input logic [31:0] tune, input logic [6:0] vel);
    i_scan_en = scan; i_flag_dds = dds; i_flag_adsr = adsr; i_note_status = st;
    i_voice_index = idx; i_tuning_code = tune; i_velocity = vel;
    @(posedge i_clk);
    model_step(scan, dds, adsr, st, int'(idx), int'(tune), int'(vel));
    #1;
    i_scan_en = 1'b0; i_flag_dds = 1'b0; i_flag_adsr = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_valid, o_frame_start, o_gate, o_trigger, o_release} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=00000",
                         {o_valid, o_frame_start, o_gate, o_trigger, o_release});
    end
    checks++;
    if ({o_voice, o_tuning_code, o_velocity, o_drop_count} !== 51'd0) begin
      errors++; $display("FAIL reset_data got voice=%0d tune=%h vel=%0d drop=%0d want all 0",
                         o_voice, o_tuning_code, o_velocity, o_drop_count);
    end
  endtask

  task automatic test_scan_frame();
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 0, 0, 8'd0, 32'd0, 7'd0);
      checks++;
      if ({o_valid, o_voice, o_frame_start, o_gate, o_trigger} !== {1'b1, 4'(i), (i == 0), 2'b00}) begin
        errors++; $display("FAIL scan_frame i=%0d got v=%b voice=%0d fs=%b g=%b t=%b", i,
                           o_valid, o_voice, o_frame_start, o_gate, o_trigger);
      end
    end
  endtask

  task automatic test_note_on();
    bit seen;
    cycle(0, 1, 1, 1, 8'd3, 32'h0123_4567, 7'd100);
    for (int f = 0; f < 2; f++) begin
      seen = 0;
      for (int i = 0; i < 16; i++) begin
        cycle(1, 0, 0, 0, 8'd0, 32'd0, 7'd0);
        if (o_voice == 4'd3) begin
          seen = 1; checks++;
          if ({o_gate, o_trigger, o_release, o_tuning_code, o_velocity} !==
              {1'b1, (f == 0), 1'b0, 32'h0123_4567, 7'd100}) begin
            errors++; $display("FAIL note_on frame=%0d got g=%b t=%b r=%b tune=%h vel=%0d", f,
                               o_gate, o_trigger, o_release, o_tuning_code, o_velocity);
          end
        end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL note_on_seen frame=%0d got 0 want 1", f); end
    end
  endtask

  task automatic test_note_off();
    bit seen;
    cycle(0, 0, 1, 0, 8'd3, 32'd0, 7'd0);
    for (int f = 0; f < 2; f++) begin
      seen = 0;
      for (int i = 0; i < 16; i++) begin
        cycle(1, 0, 0, 0, 8'd0, 32'd0, 7'd0);
        if (o_voice == 4'd3) begin
          seen = 1; checks++;
          if ({o_gate, o_trigger, o_release, o_tuning_code, o_velocity} !==
              {1'b0, 1'b0, (f == 0), 32'h0123_4567, 7'd100}) begin
            errors++; $display("FAIL note_off frame=%0d got g=%b t=%b r=%b tune=%h vel=%0d", f,
                               o_gate, o_trigger, o_release, o_tuning_code, o_velocity);
          end
        end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL note_off_seen frame=%0d got 0 want 1", f); end
    end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 16 && m_ptr != 5; i++) cycle(1, 0, 0, 0, 8'd0, 32'd0, 7'd0);
    cycle(1, 1, 1, 1, 8'd5, 32'hCAFE_0005, 7'd55);
    checks++;
    if ({o_voice, o_gate, o_trigger, o_release, o_tuning_code, o_velocity} !==
        {4'd5, 1'b1, 1'b1, 1'b0, 32'hCAFE_0005, 7'd55}) begin
      errors++; $display("FAIL collision got voice=%0d g=%b t=%b r=%b tune=%h vel=%0d",
                         o_voice, o_gate, o_trigger, o_release, o_tuning_code, o_velocity);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 0, 0, 8'd0, 32'd0, 7'd0);
      if (o_voice == 4'd5) begin
        checks++;
        if ({o_gate, o_trigger} !== 2'b10) begin
          errors++; $display("FAIL collision_next got g=%b t=%b want g=1 t=0", o_gate, o_trigger);
        end
      end
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)),
            8'd200, $urandom, 7'($urandom));
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL drop_stream i=%0d got=%h want=%h", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (o_drop_count !== 8'd255) begin
      errors++; $display("FAIL drop_sat got=%0d want=255", o_drop_count);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 0, 0, 8'd0, 32'd0, 7'd0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL drop_frame i=%0d got=%h want=%h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 1, 1, 8'd7, 32'h7777_7777, 7'd77);
    i_scan_en = 1'b1;
    do_reset();
    i_scan_en = 1'b0;
    checks++;
    if ({o_valid, o_drop_count} !== 9'd0) begin
      errors++; $display("FAIL reset_mid_out got valid=%b drop=%0d want 0 0", o_valid, o_drop_count);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 0, 0, 8'd0, 32'd0, 7'd0);
      checks++;
      if ({o_voice, o_gate, o_trigger, o_tuning_code} !== {4'(i), 1'b0, 1'b0, 32'd0}) begin
        errors++; $display("FAIL reset_mid i=%0d got voice=%0d g=%b t=%b tune=%h", i,
                           o_voice, o_gate, o_trigger, o_tuning_code);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15)),
            $urandom, 7'($urandom));
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL random i=%0d got=%h want=%h", i, got_vec(), exp_vec());
      end
      if (e_valid) begin
        checks++;
        if (o_frame_start !== e_fs) begin
          errors++; $display("FAIL random_fs i=%0d got=%b want=%b", i, o_frame_start, e_fs);
        end
      end
      checks++;
      if ((o_trigger & o_release) !== 1'b0) begin
        errors++; $display("FAIL trig_rel_excl i=%0d got=1 want=0", i);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    test_reset();
    test_scan_frame();
    test_note_on();
    test_note_off();
    test_collision();
    test_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
